// File: rtl/tpu_mac_result_collector_if.sv
// Stream bundle between the MAC result producer/consumer side and the result collector.
interface tpu_mac_result_collector_if #(
  parameter int DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] mac_result;
  logic                         mac_valid;
  logic [7:0]                   acc_len;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         mac_stall;
  logic                         busy;
  logic                         overflow;

  modport master (
    output mac_result, mac_valid, acc_len, out_ready,
    input  out_data, out_valid, mac_stall, busy, overflow
  );

  modport slave (
    input  mac_result, mac_valid, acc_len, out_ready,
    output out_data, out_valid, mac_stall, busy, overflow
  );
endinterface

// File: rtl/tpu_mac_result_collector.sv
// Sums groups of MAC beats, saturates each group result and queues it in a small FIFO.
// Optional macro TPU_RESULT_RELU_EN clamps negative group results to zero. Needs ACC_WIDTH > DATA_WIDTH.
module tpu_mac_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int FIFO_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  tpu_mac_result_collector_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                      state, state_d;
  logic signed [ACC_WIDTH-1:0] acc, acc_d, mac_ext, sum;
  logic [7:0]                  cnt, cnt_d, len_q, len_d, first_len;
  logic                        beat, complete;
  logic                        pos_ovf, neg_ovf;
  logic [DATA_WIDTH-1:0]       sat, push_val;

  logic [DATA_WIDTH-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [CNT_W-1:0]            count;
  logic                        full, pop, push, overflow_q;

  assign beat      = bus.mac_valid && !rst;
  assign mac_ext   = {{(ACC_WIDTH-DATA_WIDTH){bus.mac_result[DATA_WIDTH-1]}}, bus.mac_result};
  assign first_len = (bus.acc_len == 8'd0) ? 8'd1 : bus.acc_len;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state;
    acc_d    = acc;
    cnt_d    = cnt;
    len_d    = len_q;
    complete = 1'b0;
    sum      = mac_ext;
    if (beat) begin
      unique case (state)
        IDLE: begin
          len_d = first_len;
          if (first_len == 8'd1) begin
            complete = 1'b1;
            cnt_d    = 8'd0;
          end else begin
            acc_d   = mac_ext;
            cnt_d   = 8'd1;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          sum = acc + mac_ext;
          if (cnt == len_q - 8'd1) begin
            complete = 1'b1;
            cnt_d    = 8'd0;
            acc_d    = '0;
            state_d  = IDLE;
          end else begin
            acc_d = sum;
            cnt_d = cnt + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Out of range when the bits above the result's sign bit disagree with the true sign.
  assign pos_ovf = !sum[ACC_WIDTH-1] &&  (|sum[ACC_WIDTH-2:DATA_WIDTH-1]);
  assign neg_ovf =  sum[ACC_WIDTH-1] && !(&sum[ACC_WIDTH-2:DATA_WIDTH-1]);
  assign sat = pos_ovf ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
               neg_ovf ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
               sum[DATA_WIDTH-1:0];

`ifdef TPU_RESULT_RELU_EN
  assign push_val = sat[DATA_WIDTH-1] ? '0 : sat;
`else
  assign push_val = sat;
`endif

  assign bus.out_valid = (count != '0);
  assign full          = (count == CNT_W'(FIFO_DEPTH));
  assign pop           = bus.out_valid && bus.out_ready;
  assign push          = complete && (!full || pop);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      len_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      len_q <= len_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (complete && full && !pop) overflow_q <= 1'b1;
    end
  end

  // NOTE: storage is not reset; out_data is masked while empty so stale contents never show.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_val;
  end

  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.mac_stall = (count >= CNT_W'(FIFO_DEPTH - 1));
  assign bus.busy      = (state == ACCUM) || bus.out_valid;
  assign bus.overflow  = overflow_q;

endmodule
